// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared state encodings and default timing for the SRAM access sequencer
package sram_ctrl_pkg;
    typedef logic [2:0] state_t;
    localparam state_t IDLE    = 3'd0;
    localparam state_t SETUP   = 3'd1;
    localparam state_t WRITE   = 3'd2;
    localparam state_t READ    = 3'd3;
    localparam state_t RELEASE = 3'd4;
    localparam state_t RESP    = 3'd5;
    localparam int DEF_WR_CYC = 2;
    localparam int DEF_RD_CYC = 1;
endpackage

// File: rtl/row_decoder.sv
// row_decoder: binary word address to one-hot row select, all zero when disabled
module row_decoder #(
    parameter int ADDR_W = 2
) (
    input  logic [ADDR_W-1:0]      addr_i,
    input  logic                   en_i,
    output logic [(2**ADDR_W)-1:0] sel_o
);
    localparam int WORDS = 2**ADDR_W;
    // Shift a single one into the addressed row position
    always_comb sel_o = en_i ? (WORDS'(1) << addr_i) : '0;
endmodule

// File: rtl/sram_access_ctrl.sv
// sram_access_ctrl: sequences row select, rw strobe and data so bitcells never see a spurious write
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 2,
    parameter int DATA_W = 4,
    parameter int WR_CYC = DEF_WR_CYC,
    parameter int RD_CYC = DEF_RD_CYC
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_we,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [DATA_W-1:0]      req_wdata,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [DATA_W-1:0]      rsp_rdata,
    output logic                   wr_done,
    output logic [(2**ADDR_W)-1:0] arr_sel,
    output logic                   arr_rw,
    output logic [DATA_W-1:0]      arr_din,
    input  logic [DATA_W-1:0]      arr_dout
);
    localparam int WORDS = 2**ADDR_W;
    localparam int MAX_CYC = WR_CYC > RD_CYC ? WR_CYC : RD_CYC;
    localparam int CNT_W = $clog2(MAX_CYC + 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d, wr_done_q, wr_done_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [WORDS-1:0] arr_sel_q, arr_sel_d;
    logic arr_rw_q, arr_rw_d;
    logic [DATA_W-1:0] arr_din_q, arr_din_d;
    // Row select is derived from the next state so it is registered alongside rw/din
    row_decoder #(.ADDR_W(ADDR_W)) u_dec (
        .addr_i(addr_q),
        .en_i  (state_d == WRITE || state_d == READ),
        .sel_o (arr_sel_d)
    );
    // Next-state logic; rw/din only move on edges where no row is selected
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        wr_done_d   = 1'b0;
        arr_rw_d    = arr_rw_q;
        arr_din_d   = arr_din_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                state_d     = SETUP;
                req_ready_d = 1'b0;
                we_d        = req_we;
                addr_d      = req_addr;
                arr_rw_d    = req_we;
                arr_din_d   = req_we ? req_wdata : '0;
            end
            SETUP: begin
                state_d = we_q ? WRITE : READ;
                cnt_d   = '0;
            end
            WRITE: begin
                state_d = (cnt_q == CNT_W'(WR_CYC - 1)) ? RELEASE : WRITE;
                cnt_d   = cnt_q + 1'b1;
            end
            READ: if (cnt_q == CNT_W'(RD_CYC - 1)) begin
                state_d     = RELEASE;
                rsp_rdata_d = arr_dout;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            RELEASE: begin
                state_d     = we_q ? IDLE : RESP;
                arr_rw_d    = 1'b0;
                arr_din_d   = '0;
                wr_done_d   = we_q;
                req_ready_d = we_q;
                rsp_valid_d = !we_q;
            end
            RESP: if (rsp_ready) begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
                req_ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // State and registered outputs; reset drops every row select on the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            wr_done_q   <= 1'b0;
            arr_sel_q   <= '0;
            arr_rw_q    <= 1'b0;
            arr_din_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            wr_done_q   <= wr_done_d;
            arr_sel_q   <= arr_sel_d;
            arr_rw_q    <= arr_rw_d;
            arr_din_q   <= arr_din_d;
        end
    end
    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign wr_done   = wr_done_q;
    assign arr_sel   = arr_sel_q;
    assign arr_rw    = arr_rw_q;
    assign arr_din   = arr_din_q;
endmodule

// File: tb/tb_sram_access_ctrl.sv
// tb_sram_access_ctrl: bitcell array model plus scoreboard-checked directed access sequences
module tb_sram_access_ctrl;
    localparam int ADDR_W = 2;
    localparam int DATA_W = 4;
    localparam int WORDS = 4;
    localparam int WR_CYC = 2;
    localparam int RD_CYC = 1;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b1;
    logic [ADDR_W-1:0] req_addr = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic req_ready, rsp_valid, wr_done, arr_rw;
    logic [DATA_W-1:0] rsp_rdata, arr_din;
    logic [WORDS-1:0] arr_sel;
    tri [DATA_W-1:0] arr_dout;
    int checks = 0;
    int errors = 0;
    int wd_cnt = 0;
    logic chk_en = 1'b0;
    logic [DATA_W-1:0] exp_rd[$];
    logic [DATA_W-1:0] mem [WORDS] = '{4'h5, 4'h6, 4'h9, 4'hC};
    logic prev_rw;
    logic [DATA_W-1:0] prev_din;

    sram_access_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_CYC(WR_CYC), .RD_CYC(RD_CYC)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .wr_done(wr_done), .arr_sel(arr_sel), .arr_rw(arr_rw),
        .arr_din(arr_din), .arr_dout(arr_dout)
    );

    always #5 clk = ~clk;

    // Bitcell rows: store while selected with rw high, drive the shared bus only when selected
    always @(posedge clk) begin
        for (int r = 0; r < WORDS; r++)
            if (arr_sel[r] && arr_rw) mem[r] <= arr_din;
    end
    for (genvar r = 0; r < WORDS; r++) begin : g_row
        assign arr_dout = arr_sel[r] ? mem[r] : 4'bzzzz;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops the expected read word at every response handshake
    always @(negedge clk) begin
        if (rsp_valid === 1'b1 && rsp_ready) begin
            if (exp_rd.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected got %0h want none", rsp_rdata);
            end else begin
                chk("rsp_rdata", 32'(rsp_rdata), 32'(exp_rd.pop_front()));
            end
        end
        if (wr_done === 1'b1) wd_cnt++;
    end

    // Hazard monitor: one-hot select, and rw/din frozen whenever a row is selected
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if ($countones(arr_sel) > 1 || (arr_sel != '0 && (arr_rw !== prev_rw || arr_din !== prev_din))) begin
                errors++;
                $display("FAIL hazard sel=%b rw=%b din=%h prev_rw=%b prev_din=%h", arr_sel, arr_rw, arr_din, prev_rw, prev_din);
            end
        end
        prev_rw  = arr_rw;
        prev_din = arr_din;
    end

    task automatic txn(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                       output int sel_n, output int done_at, output int done_n, output int vld_at);
        int k = 0;
        while (req_ready !== 1'b1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("req_ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = we ? d : 4'h0;
        if (!we) exp_rd.push_back(d);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_wdata = 4'h0;
        sel_n = 0;
        done_at = -1;
        done_n = 0;
        vld_at = -1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (arr_sel == (4'b0001 << a) && arr_rw == we) sel_n++;
            if (wr_done) begin
                done_n++;
                if (done_at < 0) done_at = i;
            end
            if (rsp_valid && vld_at < 0) vld_at = i;
        end
    endtask

    initial begin
        int sn, da, dn, va;
        logic bad;
        logic [DATA_W-1:0] held;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_rdata", 32'(rsp_rdata), 32'd0);
        chk("rst_wr_done", 32'(wr_done), 32'd0);
        chk("rst_arr_sel", 32'(arr_sel), 32'd0);
        chk("rst_arr_rw", 32'(arr_rw), 32'd0);
        chk("rst_arr_din", 32'(arr_din), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;
        bad = 1'b0;
        repeat (10) begin
            @(negedge clk);
            if (arr_sel !== '0) bad = 1'b1;
        end
        chk("idle_sel_quiet", 32'(bad), 32'd0);

        txn(1'b1, 2'd2, 4'b1010, sn, da, dn, va);
        chk("wr2_sel_cycles", 32'(sn), 32'(WR_CYC));
        chk("wr2_done_count", 32'(dn), 32'd1);
        chk("wr2_done_at", 32'(da), 32'(3 + WR_CYC));
        txn(1'b0, 2'd2, 4'b1010, sn, da, dn, va);
        chk("rd2_sel_cycles", 32'(sn), 32'(RD_CYC));
        chk("rd2_valid_at", 32'(va), 32'(3 + RD_CYC));
        chk("rd2_no_wr_done", 32'(dn), 32'd0);

        txn(1'b1, 2'd0, 4'hF, sn, da, dn, va);
        chk("wr0_sel_cycles", 32'(sn), 32'(WR_CYC));
        txn(1'b1, 2'd3, 4'h0, sn, da, dn, va);
        chk("wr3_done_count", 32'(dn), 32'd1);
        txn(1'b0, 2'd0, 4'hF, sn, da, dn, va);
        txn(1'b0, 2'd3, 4'h0, sn, da, dn, va);
        txn(1'b0, 2'd1, 4'h6, sn, da, dn, va);
        txn(1'b0, 2'd2, 4'hA, sn, da, dn, va);

        rsp_ready = 1'b0;
        txn(1'b0, 2'd1, 4'h6, sn, da, dn, va);
        chk("bp_valid_at", 32'(va), 32'(3 + RD_CYC));
        held = rsp_rdata;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== held || req_ready !== 1'b0) bad = 1'b1;
        end
        chk("bp_stable", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_valid_drop", 32'(rsp_valid), 32'd0);
        chk("bp_idle_ready", 32'(req_ready), 32'd1);

        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 2'd1;
        req_wdata = 4'h3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid_wr_sel", 32'(arr_sel), 32'h2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_sel", 32'(arr_sel), 32'd0);
        chk("mid_rst_rw", 32'(arr_rw), 32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd1);
        txn(1'b1, 2'd3, 4'h9, sn, da, dn, va);
        chk("post_rst_wr_done", 32'(dn), 32'd1);
        txn(1'b0, 2'd3, 4'h9, sn, da, dn, va);
        txn(1'b0, 2'd0, 4'hF, sn, da, dn, va);

        rst       = 1'b1;
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 2'd2;
        req_wdata = 4'h5;
        @(posedge clk);
        #1;
        rst       = 1'b0;
        req_valid = 1'b0;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (arr_sel !== '0 || wr_done !== 1'b0 || req_ready !== 1'b1) bad = 1'b1;
        end
        chk("rst_beats_req", 32'(bad), 32'd0);
        txn(1'b0, 2'd2, 4'hA, sn, da, dn, va);

        repeat (3) @(negedge clk);
        chk("rd_queue_empty", 32'(exp_rd.size()), 32'd0);
        chk("wr_done_total", 32'(wd_cnt), 32'd4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got running want finished");
        $fatal(1, "timeout");
    end
endmodule
